// File: rtl/pulse_req_pkg.sv
// Shared types and default sizing for the pulse request initiator.
package pulse_req_pkg;

  // Initiator FSM: idle, driving the request pulse, waiting for acknowledge.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    WAIT  = 2'd2
  } state_e;

  localparam int DEF_CNT_W   = 8;
  localparam int DEF_TIMEOUT = 16;
  localparam int DEF_STAT_W  = 16;

endpackage

// File: rtl/pulse_req_rise_detect.sv
// Registers a 1-bit input and flags its rising edge in the cycle it is first seen high.
module rise_detect (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q,
  output logic rise
);

  // Delayed copy of the input; cleared on reset so a level already high after reset counts as a rise.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= 1'b0;
    end else begin
      q <= d;
    end
  end

  assign rise = d & ~q;

endmodule

// File: rtl/pulse_req_initiator.sv
// Initiator of the single-wire pulse request/response handshake: drives a request
// pulse, waits for a rising acknowledge, reports done/timeout and counts outcomes.
module pulse_req_initiator
  import pulse_req_pkg::*;
#(
  parameter int CNT_W   = DEF_CNT_W,
  parameter int TIMEOUT = DEF_TIMEOUT,
  parameter int STAT_W  = DEF_STAT_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [CNT_W-1:0]  pulse_len,
  output logic              in_signal,
  input  logic              out_signal,
  output logic              busy,
  output logic              done,
  output logic              timeout,
  output logic [STAT_W-1:0] pass_count,
  output logic [STAT_W-1:0] fail_count
);

  localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0]  TIMEOUT_V = CNT_W'(TIMEOUT);
  localparam logic [STAT_W-1:0] STAT_ONE  = STAT_W'(1);

  state_e           state;
  logic [CNT_W-1:0] cnt;
  logic             out_q;
  logic             ack;

  // Acknowledge is a rising edge of out_signal, judged against its registered copy.
  rise_detect u_rise (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (out_signal),
    .q     (out_q),
    .rise  (ack)
  );

  assign busy = (state != IDLE);

  // Request FSM with registered request pulse, completion pulses and saturating statistics.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      in_signal  <= 1'b0;
      done       <= 1'b0;
      timeout    <= 1'b0;
      pass_count <= '0;
      fail_count <= '0;
    end else begin
      // NOTE: the completion pulses default low every cycle and are only raised by the WAIT
      // exit below, which is what makes them exactly one cycle wide.
      done    <= 1'b0;
      timeout <= 1'b0;
      unique case (state)
        IDLE: begin
          in_signal <= 1'b0;
          if (start) begin
            state     <= DRIVE;
            cnt       <= (pulse_len == '0) ? CNT_ONE : pulse_len;
            in_signal <= 1'b1;
          end
        end
        DRIVE: begin
          if (cnt == CNT_ONE) begin
            state     <= WAIT;
            in_signal <= 1'b0;
            cnt       <= TIMEOUT_V;
          end else begin
            cnt <= cnt - CNT_ONE;
          end
        end
        WAIT: begin
          // Acknowledge takes priority over expiry in the same cycle.
          if (ack) begin
            state <= IDLE;
            done  <= 1'b1;
            if (pass_count != '1) pass_count <= pass_count + STAT_ONE;
          end else if (cnt == CNT_ONE) begin
            state   <= IDLE;
            timeout <= 1'b1;
            if (fail_count != '1) fail_count <= fail_count + STAT_ONE;
          end else begin
            cnt <= cnt - CNT_ONE;
          end
        end
        default: begin
          state     <= IDLE;
          in_signal <= 1'b0;
        end
      endcase
    end
  end

  // Protocol invariants of the initiator.
  a_req_only_in_drive: assert property (@(posedge clk) disable iff (!rst_n)
    in_signal |-> (state == DRIVE));
  a_done_from_wait: assert property (@(posedge clk) disable iff (!rst_n)
    done |-> ($past(state) == WAIT));
  a_done_timeout_excl: assert property (@(posedge clk) disable iff (!rst_n)
    $onehot0({done, timeout}));

endmodule

// File: doc/pulse_req_initiator.md
Name: pulse_req_initiator

Overview:
Initiator end of the single-wire pulse request/response interface: drives a request pulse on `in_signal` toward a responder (e.g. m_simple) and waits for a rising edge on `out_signal` as acknowledgement.
- Reports each transaction as done or timeout and keeps saturating pass/fail counters.
- Sits in the block that originates requests to the responder; it is also the synthesizable stimulus source used by the SVA lint benches.

Parameters:
- CNT_W, 8: width of the pulse length input and of the internal cycle counter.
- TIMEOUT, 16: cycles allowed in WAIT for an acknowledge edge; legal range 1 to 2**CNT_W-1.
- STAT_W, 16: width of the pass/fail statistic counters.

Ports:
- clk  input  1  single clock; all logic on posedge.
- rst_n  input  1  reset, asynchronous, active-low.
- start  input  1  request a transaction; sampled only in IDLE.
- pulse_len  input  CNT_W  request pulse length in cycles; sampled with start; 0 treated as 1.
- in_signal  output  1  request pulse to responder, registered.
- out_signal  input  1  acknowledge from responder, same clock domain.
- busy  output  1  high whenever state is not IDLE.
- done  output  1  one-cycle pulse: acknowledge received.
- timeout  output  1  one-cycle pulse: no acknowledge within TIMEOUT.
- pass_count  output  STAT_W  number of done events, saturating.
- fail_count  output  STAT_W  number of timeout events, saturating.

Behaviour:
- Reset (rst_n low, asynchronous):
  - state = IDLE; in_signal, busy, done and timeout = 0.
  - cnt, pass_count, fail_count and out_q (the registered copy of out_signal) = 0.
  - Takes effect mid-transaction with no completion pulse.
- FSM states: IDLE, DRIVE, WAIT.
- IDLE:
  - in_signal = 0.
  - start = 1 at edge N: state goes to DRIVE, cnt = max(pulse_len, 1), in_signal = 1 from edge N.
- DRIVE:
  - in_signal stays 1 and cnt decrements each cycle.
  - When cnt == 1: state goes to WAIT, in_signal = 0, cnt = TIMEOUT.
  - in_signal is high for exactly max(pulse_len, 1) cycles.
- WAIT:
  - Acknowledge = out_signal == 1 && out_q == 0 (rising edge).
  - On acknowledge: state goes to IDLE, done = 1 for one cycle, pass_count increments.
  - Else if cnt == 1: state goes to IDLE, timeout = 1 for one cycle, fail_count increments.
  - Else cnt decrements.
- Acknowledge edges seen during IDLE or DRIVE are ignored. If out_signal is already high on entry to WAIT, it must fall and rise again to count.
- If the acknowledge and timeout expiry fall in the same cycle, done wins and timeout is not asserted.
- start is ignored while busy. It is not queued.
- start in the same cycle a done or timeout is issued is ignored (state is not IDLE at that edge). The earliest accepted restart is one cycle later.
- done and timeout are never high together.
- busy = (state != IDLE), combinational from the state register.
- Counters saturate at 2**STAT_W-1 and never wrap.
- Latency:
  - start to in_signal rise: 1 edge.
  - out_signal rise (in WAIT) to done: same edge that samples it.
- Embedded assertions:
  - in_signal never high outside DRIVE.
  - done implies the previous state was WAIT.
  - $onehot0({done, timeout}).

Decomposition:
- Package pulse_req_pkg holds:
  - state_e enum {IDLE, DRIVE, WAIT}.
  - Default constants DEF_CNT_W = 8, DEF_TIMEOUT = 16, DEF_STAT_W = 16.
- One natural sub-module: rise_detect (registers a 1-bit input and produces a rise pulse; async active-low reset clears it to 0). It is instantiated on out_signal.
- Counter saturation is kept inline.

Test Plan:
- Reset then idle: rst_n low 3 cycles, then high 10 cycles, no start -> in_signal 0, busy 0, counters 0 throughout.
- Normal transaction: pulse_len = 3, start for 1 cycle; responder raises out_signal 2 cycles after in_signal falls -> in_signal high exactly 3 cycles, done 1 cycle, pass_count = 1, busy then 0.
- Timeout: TIMEOUT = 16, pulse_len = 1, out_signal held 0 -> timeout pulses 16 cycles after WAIT entry, fail_count = 1, done never set.
- Edge cases:
  - pulse_len = 0 -> 1-cycle pulse.
  - out_signal held high across WAIT entry -> timeout.
  - out_signal rises on the final WAIT cycle -> done, no timeout.
- Busy/reset: start re-asserted during DRIVE -> ignored, one pulse only. rst_n dropped mid-WAIT -> in_signal, busy and counters 0 immediately, no done or timeout. Saturation: preload STAT_W = 2, run 5 passes -> pass_count stays 3.
